// File: rtl/hack_cpu.sv
// ---------------------------------------------------------------------------
// hack_cpu
//
// Hack-architecture CPU core. Fetches 16-bit instructions from a boot ROM
// and executes each one in a fixed FETCH -> DECODE -> EXECUTE sequence. The
// three states absorb the one-cycle read latency of both the instruction ROM
// and the data memory:
//   FETCH   : ROM address = pc. The ROM returns the word on the next edge.
//   DECODE  : ir captures the ROM word. The data memory address (A) is
//             presented, so the M operand is ready in EXECUTE.
//   EXECUTE : ALU evaluation, register/memory writes and the pc update.
// The core only advances when clken and rom_ready are both high. It stays
// parked at pc 0 until the ROM has finished loading.
//
// Ports
//   clk          in   1  system clock
//   reset        in   1  asynchronous active-high reset
//   clken        in   1  global clock enable; all state holds while low
//   rom_ready    in   1  ROM load complete; the core is frozen while low
//   rom_address  out 16  {1'b0, pc}
//   instruction  in  16  ROM read data, one cycle after the address
//   mem_address  out 15  data memory address = A[14:0]
//   mem_rdata    in  16  data memory read data, one cycle after the address
//   mem_wdata    out 16  ALU result
//   mem_write    out  1  data memory write strobe (EXECUTE only)
//   pc           out 15  program counter, for debug
// ---------------------------------------------------------------------------
module hack_cpu (
    input  logic        clk,
    input  logic        reset,
    input  logic        clken,
    input  logic        rom_ready,
    output logic [15:0] rom_address,
    input  logic [15:0] instruction,
    output logic [14:0] mem_address,
    input  logic [15:0] mem_rdata,
    output logic [15:0] mem_wdata,
    output logic        mem_write,
    output logic [14:0] pc
);

    typedef enum logic [1:0] {
        ST_FETCH   = 2'd0,
        ST_DECODE  = 2'd1,
        ST_EXECUTE = 2'd2
    } state_t;

    // Hack ALU. ctl = {zx, nx, zy, ny, f, no}; the steps are applied in order.
    function automatic logic [15:0] hack_alu(
        input logic [15:0] x_in,
        input logic [15:0] y_in,
        input logic [5:0]  ctl
    );
        logic [15:0] x_v;
        logic [15:0] y_v;
        logic [15:0] o_v;
        x_v = ctl[5] ? 16'h0000 : x_in;
        x_v = ctl[4] ? ~x_v     : x_v;
        y_v = ctl[3] ? 16'h0000 : y_in;
        y_v = ctl[2] ? ~y_v     : y_v;
        // Carry out of bit 15 is dropped: 16-bit modular add.
        o_v = ctl[1] ? (x_v + y_v) : (x_v & y_v);
        o_v = ctl[0] ? ~o_v : o_v;
        return o_v;
    endfunction

    // Architectural state
    state_t      state_r;
    state_t      state_next_s;
    logic [14:0] pc_r;
    logic [15:0] a_r;
    logic [15:0] d_r;
    logic [15:0] ir_r;

    // Control and decode
    logic        go_s;
    logic        is_c_s;
    logic        sel_m_s;
    logic [5:0]  alu_ctl_s;
    logic        dest_a_s;
    logic        dest_d_s;
    logic        dest_m_s;
    logic [2:0]  jmp_s;
    logic [15:0] alu_y_s;
    logic [15:0] alu_out_s;
    logic        zr_s;
    logic        ng_s;
    logic        jump_s;
    logic [14:0] pc_inc_s;
    logic        mem_write_s;
    // ir[14:13] have no meaning in a C-instruction; folded here so the
    // unused bits are visibly accounted for.
    logic        ir_unused_s;

    assign go_s        = clken & rom_ready;

    assign is_c_s      = ir_r[15];
    assign sel_m_s     = ir_r[12];
    assign alu_ctl_s   = ir_r[11:6];
    assign dest_a_s    = ir_r[5];
    assign dest_d_s    = ir_r[4];
    assign dest_m_s    = ir_r[3];
    assign jmp_s       = ir_r[2:0];
    assign ir_unused_s = ^ir_r[14:13];

    assign alu_y_s     = sel_m_s ? mem_rdata : a_r;
    assign alu_out_s   = hack_alu(d_r, alu_y_s, alu_ctl_s);
    assign zr_s        = (alu_out_s == 16'h0000);
    assign ng_s        = alu_out_s[15];
    assign jump_s      = (jmp_s[2] & ng_s) | (jmp_s[1] & zr_s) | (jmp_s[0] & ~zr_s & ~ng_s);
    // 15-bit increment wraps 0x7FFF -> 0x0000 naturally.
    assign pc_inc_s    = pc_r + 15'd1;

    // FSM state register: advances only on a go cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_FETCH;
        end else if (go_s) begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic: fixed three-step cycle per instruction.
    always_comb begin
        state_next_s = ST_FETCH;
        case (state_r)
            ST_FETCH:   state_next_s = ST_DECODE;
            ST_DECODE:  state_next_s = ST_EXECUTE;
            ST_EXECUTE: state_next_s = ST_FETCH;
            default:    state_next_s = ST_FETCH;
        endcase
    end

    // FSM output logic: the write strobe exists only in a go cycle of EXECUTE
    // for a C-instruction with d3 set. Because state_r is cleared
    // asynchronously, a reset during EXECUTE drops the strobe at once.
    always_comb begin
        mem_write_s = 1'b0;
        if ((state_r == ST_EXECUTE) && is_c_s && dest_m_s && go_s) begin
            mem_write_s = 1'b1;
        end else begin
            mem_write_s = 1'b0;
        end
    end

    // Instruction register: captures the ROM word at the DECODE edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ir_r <= 16'h0000;
        end else if (go_s && (state_r == ST_DECODE)) begin
            ir_r <= instruction;
        end
    end

    // A, D and pc update at the EXECUTE edge. The jump target and the memory
    // address both use the A value from before this edge, since A is only
    // replaced by the non-blocking update below.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_r  <= 16'h0000;
            d_r  <= 16'h0000;
            pc_r <= 15'd0;
        end else if (go_s && (state_r == ST_EXECUTE)) begin
            if (!is_c_s) begin
                a_r  <= {1'b0, ir_r[14:0]};
                pc_r <= pc_inc_s;
            end else begin
                if (dest_a_s) begin
                    a_r <= alu_out_s;
                end
                if (dest_d_s) begin
                    d_r <= alu_out_s;
                end
                pc_r <= jump_s ? a_r[14:0] : pc_inc_s;
            end
        end
    end

    assign rom_address = {1'b0, pc_r};
    assign mem_address = a_r[14:0];
    assign mem_wdata   = alu_out_s;
    assign mem_write   = mem_write_s;
    assign pc          = pc_r;

endmodule

// File: tb/tb_hack_cpu.sv
module tb_hack_cpu;

    logic        clk = 1'b0;
    logic        reset;
    logic        clken;
    logic        rom_ready;
    logic [15:0] rom_address;
    logic [15:0] instruction;
    logic [14:0] mem_address;
    logic [15:0] mem_rdata;
    logic [15:0] mem_wdata;
    logic        mem_write;
    logic [14:0] pc;

    always #5 clk = ~clk;

    hack_cpu dut (
        .clk         (clk),
        .reset       (reset),
        .clken       (clken),
        .rom_ready   (rom_ready),
        .rom_address (rom_address),
        .instruction (instruction),
        .mem_address (mem_address),
        .mem_rdata   (mem_rdata),
        .mem_wdata   (mem_wdata),
        .mem_write   (mem_write),
        .pc          (pc)
    );

    // Environment: ROM and data RAM with one-cycle read latency.
    logic [15:0] rom     [0:32767];
    logic [15:0] env_ram [0:32767];
    logic [31:0] wq [$];   // observed writes {1'b0, addr, data}

    always @(posedge clk) begin
        instruction <= rom[rom_address[14:0]];
        mem_rdata   <= env_ram[mem_address];
        if (mem_write === 1'b1) begin
            env_ram[mem_address] <= mem_wdata;
            wq.push_back({1'b0, mem_address, mem_wdata});
        end
    end

    // Reference model: instruction-level interpreter.
    logic [15:0] ref_ram [0:32767];
    logic [14:0] ref_pc;
    logic [15:0] ref_a;
    logic [15:0] ref_d;
    bit          exp_w;
    logic [31:0] exp_word;
    logic [31:0] last_w;
    int          last_wcount;

    int vectors     = 0;
    int miscompares = 0;

    task automatic ref_step;
        logic [15:0] i;
        int x, y, o;
        bit zr, ng, jump;
        logic [14:0] next_pc;
        i = rom[ref_pc];
        exp_w = 1'b0;
        if (i[15] == 1'b0) begin
            ref_a  = {1'b0, i[14:0]};
            ref_pc = ref_pc + 15'd1;
        end else begin
            x = ref_d;
            y = i[12] ? int'(ref_ram[ref_a[14:0]]) : int'(ref_a);
            if (i[11]) x = 0;
            if (i[10]) x = 65535 - x;
            if (i[9])  y = 0;
            if (i[8])  y = 65535 - y;
            o = i[7] ? (x + y) % 65536 : (x & y);
            if (i[6])  o = 65535 - o;
            zr = (o == 0);
            ng = (o >= 32768);
            jump = (i[2] && ng) || (i[1] && zr) || (i[0] && !zr && !ng);
            if (i[3]) begin
                exp_w    = 1'b1;
                exp_word = {1'b0, ref_a[14:0], o[15:0]};
                ref_ram[ref_a[14:0]] = o[15:0];
            end
            next_pc = jump ? ref_a[14:0] : ref_pc + 15'd1;
            if (i[5]) ref_a = o[15:0];
            if (i[4]) ref_d = o[15:0];
            ref_pc = next_pc;
        end
    endtask

    task automatic cyc(input logic ce, input logic rr);
        clken     = ce;
        rom_ready = rr;
        @(posedge clk);
        #1;
    endtask

    // nstall cycles with go low (clken or rom_ready low), then one go cycle.
    task automatic go_cycle(input int nstall);
        logic ce, rr;
        for (int k = 0; k < nstall; k++) begin
            ce = 1'($urandom_range(0, 1));
            rr = ce ? 1'b0 : 1'($urandom_range(0, 1));
            cyc(ce, rr);
        end
        cyc(1'b1, 1'b1);
    endtask

    task automatic run_instr(input int stall_lo, input int stall_hi);
        ref_step();
        for (int s = 0; s < 3; s++) go_cycle(int'($urandom_range(stall_lo, stall_hi)));
        vectors++;
        if (pc !== ref_pc) begin
            miscompares++;
            $display("FAIL pc: got %h expected %h", pc, ref_pc);
        end
        vectors++;
        if (mem_address !== ref_a[14:0]) begin
            miscompares++;
            $display("FAIL mem_address(A): got %h expected %h", mem_address, ref_a[14:0]);
        end
        vectors++;
        last_wcount = wq.size();
        last_w = (wq.size() > 0) ? wq[0] : 32'hFFFF_FFFF;
        if (wq.size() != (exp_w ? 1 : 0)) begin
            miscompares++;
            $display("FAIL write_count: got %0d expected %0d", wq.size(), exp_w ? 1 : 0);
        end else if (exp_w) begin
            vectors++;
            if (wq[0] !== exp_word) begin
                miscompares++;
                $display("FAIL write: got %h expected %h", wq[0], exp_word);
            end
        end
        wq.delete();
    endtask

    task automatic do_reset;
        reset = 1'b1;
        clken = 1'b0;
        rom_ready = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        ref_pc = 15'd0;
        ref_a  = 16'h0000;
        ref_d  = 16'h0000;
        wq.delete();
    endtask

    task automatic clear_rom;
        for (int k = 0; k < 32768; k++) rom[k] = 16'h0000;
    endtask

    task automatic check_pc(input string name, input logic [14:0] want);
        vectors++;
        if (pc !== want) begin
            miscompares++;
            $display("FAIL %s: got pc %h expected %h", name, pc, want);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        clken = 1'b1;
        rom_ready = 1'b0;
        @(posedge clk);
        #1;
        vectors++;
        if ({rom_address, mem_address, mem_wdata, mem_write, pc} !== 64'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got ra=%h ma=%h wd=%h mw=%b pc=%h expected all 0",
                     rom_address, mem_address, mem_wdata, mem_write, pc);
        end
        reset = 1'b0;
        for (int k = 0; k < 10; k++) begin
            cyc(1'b1, 1'b0);
            vectors++;
            if (rom_address !== 16'h0000 || mem_write !== 1'b0) begin
                miscompares++;
                $display("FAIL rom_not_ready: got ra=%h mw=%b expected 0/0", rom_address, mem_write);
            end
        end
        // Still in FETCH at pc 0: the first instruction needs exactly 3 go cycles.
        ref_pc = 15'd0; ref_a = 16'h0000; ref_d = 16'h0000;
        wq.delete();
        clear_rom();
        rom[0] = 16'h0123;
        run_instr(0, 0);
    endtask

    task automatic load_pgm1;
        clear_rom();
        rom[0] = 16'h0005;
        rom[1] = 16'hEC10;
        rom[2] = 16'hE7C8;
    endtask

    task automatic test_basic(input int stall);
        load_pgm1();
        do_reset();
        for (int k = 0; k < 3; k++) run_instr(stall, stall);
        vectors++;
        if (last_wcount != 1 || last_w !== {1'b0, 15'd5, 16'd6}) begin
            miscompares++;
            $display("FAIL m_eq_d_plus_1: got %0d writes, %h expected 1 write, %h",
                     last_wcount, last_w, {1'b0, 15'd5, 16'd6});
        end
        check_pc("pgm1_pc", 15'd3);
    endtask

    task automatic test_read_m;
        clear_rom();
        rom[0] = 16'h0007;
        rom[1] = 16'hFC10;   // D=M
        rom[2] = 16'h0008;
        rom[3] = 16'hE308;   // M=D
        env_ram[7] = 16'h1234; ref_ram[7] = 16'h1234;
        do_reset();
        for (int k = 0; k < 4; k++) run_instr(0, 1);
        vectors++;
        if (last_w !== {1'b0, 15'd8, 16'h1234}) begin
            miscompares++;
            $display("FAIL d_from_m: got %h expected %h", last_w, {1'b0, 15'd8, 16'h1234});
        end
    endtask

    task automatic test_jump(input logic [15:0] dinstr, input logic [14:0] want);
        clear_rom();
        rom[0] = 16'h000A;
        rom[1] = dinstr;
        rom[2] = 16'h0009;
        rom[3] = 16'hE301;   // D;JGT
        do_reset();
        for (int k = 0; k < 4; k++) run_instr(0, 1);
        check_pc("jgt", want);
    endtask

    task automatic test_jmp_a15;
        clear_rom();
        rom[0] = 16'h7FFF;
        rom[1] = 16'hEC10;   // D=A
        rom[2] = 16'h0004;
        rom[3] = 16'hE0A0;   // A=D+A -> 0x8003
        rom[4] = 16'hEA87;   // 0;JMP
        do_reset();
        for (int k = 0; k < 5; k++) run_instr(0, 0);
        check_pc("jmp_a15_ignored", 15'h0003);
    endtask

    task automatic test_wrap;
        clear_rom();
        rom[0] = 16'h7FFF;
        rom[1] = 16'hEA87;
        rom[15'h7FFF] = 16'h0001;
        do_reset();
        run_instr(0, 0);
        run_instr(0, 0);
        check_pc("jump_to_top", 15'h7FFF);
        run_instr(0, 0);
        check_pc("pc_wrap", 15'h0000);
    endtask

    task automatic test_reset_in_execute;
        load_pgm1();
        do_reset();
        run_instr(0, 0);
        run_instr(0, 0);
        go_cycle(0);
        go_cycle(0);
        // Now in EXECUTE of M=D+1 with go high.
        clken = 1'b1;
        rom_ready = 1'b1;
        #1;
        vectors++;
        if (mem_write !== 1'b1) begin
            miscompares++;
            $display("FAIL write_strobe_execute: got %b expected 1", mem_write);
        end
        reset = 1'b1;
        #1;
        vectors++;
        if (mem_write !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_kills_write: got %b expected 0", mem_write);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_pc("pc_after_reset", 15'd0);
        vectors++;
        if (wq.size() != 0) begin
            miscompares++;
            $display("FAIL no_write_on_reset: got %0d writes expected 0", wq.size());
        end
        wq.delete();
    endtask

    task automatic test_random;
        logic [15:0] v;
        for (int k = 0; k < 32768; k++) begin
            if ($urandom_range(0, 1) == 0) begin
                v = {1'b0, 15'($urandom)};
            end else begin
                v = 16'($urandom);
                v[15] = 1'b1;
                if ($urandom_range(0, 3) != 0) v[2:0] = 3'b000;
            end
            rom[k] = v;
        end
        do_reset();
        for (int k = 0; k < 250; k++) run_instr(0, 2);
    endtask

    initial begin
        reset = 1'b1;
        clken = 1'b0;
        rom_ready = 1'b0;
        for (int k = 0; k < 32768; k++) begin
            env_ram[k] = 16'($urandom);
            ref_ram[k] = env_ram[k];
        end
        clear_rom();
        test_reset();
        test_basic(0);
        test_read_m();
        test_jump(16'hEC10, 15'd9);   // D=10 > 0: taken
        test_jump(16'hEA90, 15'd4);   // D=0: falls through
        test_jmp_a15();
        test_wrap();
        test_basic(2);                // stalls in every state
        test_reset_in_execute();
        test_basic(0);                // clean run after reset
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
